// File: rtl/bram_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// bram_scan_ctrl_if
// Groups every non-clock/reset signal of the BRAM scan controller.
//   master : the scan controller (drives BRAM reads, sample stream, status)
//   slave  : the environment (system FSM, loader, BRAM, detector core)
// Signals:
//   start, load_active         : system FSM level request / loader activity
//   bram_rd_en, bram_rd_addr   : BRAM read strobe and address
//   bram_rd_data               : BRAM data, valid one cycle after the strobe
//   smp_valid/ready/data/idx/last : sample stream towards the detector core
//   busy, done, abort          : scan status and one-cycle event pulses
// ---------------------------------------------------------------------------
interface bram_scan_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) ();

  logic              start;
  logic              load_active;
  logic              bram_rd_en;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [DATA_W-1:0] bram_rd_data;
  logic              smp_valid;
  logic              smp_ready;
  logic [DATA_W-1:0] smp_data;
  logic [ADDR_W-1:0] smp_idx;
  logic              smp_last;
  logic              busy;
  logic              done;
  logic              abort;

  modport master (
    input  start, load_active, bram_rd_data, smp_ready,
    output bram_rd_en, bram_rd_addr, smp_valid, smp_data, smp_idx, smp_last,
           busy, done, abort
  );

  modport slave (
    output start, load_active, bram_rd_data, smp_ready,
    input  bram_rd_en, bram_rd_addr, smp_valid, smp_data, smp_idx, smp_last,
           busy, done, abort
  );

endinterface

// File: rtl/bram_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bram_scan_ctrl
// Reads SAMPLE_CNT samples out of a BRAM (addresses 0..SAMPLE_CNT-1) once per
// rising edge of start and streams them to the detector core through a
// 2-entry skid FIFO with valid/ready flow control.
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : bram_scan_ctrl_if master modport (BRAM read port, sample stream,
//          start/load_active requests, busy/done/abort status)
// ---------------------------------------------------------------------------
module bram_scan_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int SAMPLE_CNT = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  bram_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_CNT - 1);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inFlight_q, inFlight_d;
  logic [ADDR_W-1:0] inFlightIdx_q, inFlightIdx_d;
  logic [DATA_W-1:0] fifoData_q [2];
  logic [DATA_W-1:0] fifoData_d [2];
  logic [ADDR_W-1:0] fifoIdx_q [2];
  logic [ADDR_W-1:0] fifoIdx_d [2];
  logic              wrPtr_q, wrPtr_d;
  logic              rdPtr_q, rdPtr_d;
  logic [1:0]        count_q, count_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic              smpValid;
  logic              pop;
  logic              lastXfer;
  logic              cancel;
  logic              startEdge;
  logic              rdEn;
  logic [2:0]        occAfterPop;

  // A start that is already high when reset is released must not count as a
  // rising edge, so edges are only honoured after start has been seen low.
  assign startEdge = bus.start && !start_q && armed_q;

  assign smpValid  = (count_q != 2'd0);
  assign pop       = smpValid && bus.smp_ready;

  // The last sample leaving in DRAIN wins over a simultaneous cancel request.
  assign lastXfer  = (state_q == DRAIN) && pop && (fifoIdx_q[rdPtr_q] == LAST_ADDR);
  assign cancel    = ((state_q == SCAN) || (state_q == DRAIN)) &&
                     (!bus.start || bus.load_active) && !lastXfer;

  // Slots that stay committed after this cycle's pop: queued samples plus the
  // read whose data is arriving now. A new read needs one free slot.
  assign occAfterPop = {1'b0, count_q} + {2'b00, inFlight_q} - {2'b00, pop};

  assign bus.bram_rd_en   = rdEn;
  assign bus.bram_rd_addr = addr_q;
  assign bus.smp_valid    = smpValid;
  assign bus.smp_data     = fifoData_q[rdPtr_q];
  assign bus.smp_idx      = fifoIdx_q[rdPtr_q];
  assign bus.smp_last     = smpValid && (fifoIdx_q[rdPtr_q] == LAST_ADDR);
  assign bus.busy         = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done         = done_q;
  assign bus.abort        = abort_q;

  // Next-state logic: scan FSM, read issue, address counter and skid FIFO.
  always_comb begin
    state_d       = state_q;
    start_d       = bus.start;
    armed_d       = armed_q || !bus.start;
    addr_d        = addr_q;
    inFlight_d    = 1'b0;
    inFlightIdx_d = inFlightIdx_q;
    fifoData_d    = fifoData_q;
    fifoIdx_d     = fifoIdx_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    rdEn          = 1'b0;

    rdEn = (state_q == SCAN) && !cancel && (occAfterPop < 3'd2);

    if (rdEn) begin
      inFlight_d    = 1'b1;
      inFlightIdx_d = addr_q;
    end

    case (state_q)
      IDLE: begin
        if (startEdge && !bus.load_active) begin
          state_d = SCAN;
          addr_d  = '0;
        end
      end
      SCAN: begin
        if (cancel) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (rdEn) begin
          // Stop at the last address instead of wrapping; it is then held.
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (lastXfer) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else if (cancel) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      HOLD: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A cancel empties the FIFO and discards the read data arriving this cycle.
    if (cancel) begin
      wrPtr_d    = 1'b0;
      rdPtr_d    = 1'b0;
      count_d    = 2'd0;
      inFlight_d = 1'b0;
    end else begin
      if (inFlight_q) begin
        fifoData_d[wrPtr_q] = bus.bram_rd_data;
        fifoIdx_d[wrPtr_q]  = inFlightIdx_q;
        wrPtr_d             = !wrPtr_q;
      end
      if (pop) begin
        rdPtr_d = !rdPtr_q;
      end
      count_d = count_q + {1'b0, inFlight_q} - {1'b0, pop};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      armed_q       <= 1'b0;
      addr_q        <= '0;
      inFlight_q    <= 1'b0;
      inFlightIdx_q <= '0;
      fifoData_q    <= '{default: '0};
      fifoIdx_q     <= '{default: '0};
      wrPtr_q       <= 1'b0;
      rdPtr_q       <= 1'b0;
      count_q       <= 2'd0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      armed_q       <= armed_d;
      addr_q        <= addr_d;
      inFlight_q    <= inFlight_d;
      inFlightIdx_q <= inFlightIdx_d;
      fifoData_q    <= fifoData_d;
      fifoIdx_q     <= fifoIdx_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
    end
  end

endmodule

// File: doc/bram_scan_ctrl.md
BRAM_SCAN_CTRL -- requirements
Module: bram_scan_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM address width.
REQ-002 Parameter DATA_W, default 16, sample width.
REQ-003 Parameter SAMPLE_CNT, default 1024, samples per scan, range 2..2^ADDR_W.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  level request from system FSM, high while RUNNING.
REQ-007 load_active  input  1  high while BRAM is being written by the loader.
REQ-008 bram_rd_en  output  1  BRAM read strobe.
REQ-009 bram_rd_addr  output  ADDR_W  BRAM read address.
REQ-010 bram_rd_data  input  DATA_W  BRAM read data, valid exactly 1 cycle after bram_rd_en.
REQ-011 smp_valid  output  1  sample stream valid to detector core.
REQ-012 smp_ready  input  1  detector core accepts sample.
REQ-013 smp_data  output  DATA_W  sample value.
REQ-014 smp_idx  output  ADDR_W  sample index (BRAM address it came from).
REQ-015 smp_last  output  1  high with the sample whose index is SAMPLE_CNT-1.
REQ-016 busy  output  1  high in SCAN and DRAIN.
REQ-017 done  output  1  one-cycle pulse when the last sample is accepted.
REQ-018 abort  output  1  one-cycle pulse when a scan is cancelled.

Function
REQ-019 FSM states IDLE, SCAN, DRAIN, HOLD; encoding free.
REQ-020 IDLE->SCAN on rising edge of start (start high, registered start low previous cycle) with load_active low; start edge while load_active high is ignored.
REQ-021 SCAN: issue reads at addresses 0,1,...,SAMPLE_CNT-1 in order, each address exactly once, no gaps forced except by back-pressure.
REQ-022 Output path: 2-entry FIFO (skid buffer); read issued in a cycle only if FIFO occupancy plus in-flight reads (0 or 1) is < 2 after accounting for a same-cycle pop.
REQ-023 With smp_ready held high, first read in cycle after SCAN entry, smp_valid first high 2 cycles after SCAN entry, then one sample per cycle (throughput 1/clk).
REQ-024 Transfer occurs when smp_valid and smp_ready both high; smp_data/smp_idx/smp_last stable while smp_valid high and smp_ready low.
REQ-025 FIFO never overflows; no sample dropped or duplicated under any smp_ready pattern.
REQ-026 SCAN->DRAIN after read of address SAMPLE_CNT-1 issued; DRAIN issues no reads.
REQ-027 DRAIN->HOLD on transfer of sample with smp_last; done pulses in that same cycle (registered, high in the cycle following the transfer, exactly one cycle).
REQ-028 HOLD->IDLE when start low; no rescan while start stays high.
REQ-029 Abort: start low or load_active high while in SCAN or DRAIN -> flush FIFO, drop in-flight read data, smp_valid low next cycle, abort pulses one cycle, state IDLE; done not asserted.
REQ-030 Abort and last-sample transfer in same cycle: transfer completes, done wins, no abort.
REQ-031 Address counter width ADDR_W; no wrap past SAMPLE_CNT-1; for SAMPLE_CNT = 2^ADDR_W last address is all-ones, no wrap to 0 issued.
REQ-032 bram_rd_en low in IDLE, DRAIN, HOLD; bram_rd_addr holds last value when idle.

Reset
REQ-033 On rstn low at a clock edge: state IDLE, FIFO empty, in-flight flag clear, address 0, start edge register 0.
REQ-034 Reset values: bram_rd_en 0, bram_rd_addr 0, smp_valid 0, smp_data 0, smp_idx 0, smp_last 0, busy 0, done 0, abort 0.
REQ-035 Reset mid-scan behaves as REQ-033/034 with no done or abort pulse; start already high after reset release does not begin a scan until a new rising edge.

Verification
REQ-036 SAMPLE_CNT=8, BRAM[i]=i*3, smp_ready=1, start rises -> smp_idx 0..7, data 0,3,...,21 on 8 consecutive cycles, smp_last with idx 7, done 1 cycle later, busy low after.
REQ-037 Same data, smp_ready toggling 1,0,0,1 random pattern -> exactly 8 transfers in order, data stable during stalls, bram_rd_en never raised with FIFO full.
REQ-038 load_active high at start edge -> no bram_rd_en, busy stays 0; load_active raised at idx 3 -> abort pulse, smp_valid 0 next cycle, state IDLE, no done.
REQ-039 start held high after done -> no second scan; start low then high -> full rescan from idx 0.
REQ-040 rstn low during DRAIN -> all outputs 0 next cycle, no done/abort pulse; start already high after release -> idle until new edge.
REQ-041 ADDR_W=3, SAMPLE_CNT=8 -> last address 7, bram_rd_addr never returns to 0 within scan.
